// File: rtl/rsa_pkg.sv
// Shared widths, FSM state encoding and latency helper for the RSA decrypt core.
package rsa_pkg;

  localparam int DW = 5;
  localparam int AW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_INIT,
    S_EXP,
    S_WRITE,
    S_DONE
  } state_t;

  // Cycles from the ds-sampling cycle to the d_d pulse on a valid operation.
  function automatic int rsa_dec_latency(input int dw);
    return 4 + 2 * dw * (1 + 2 * dw);
  endfunction

endpackage

// File: rtl/rsa_decrypt_core_if.sv
// Bus bundle of the decrypt core: ciphertext write, decrypt request, plaintext read, status.
interface rsa_decrypt_core_if #(
  parameter int DW = rsa_pkg::DW,
  parameter int AW = rsa_pkg::AW
);
  logic          ct_wren;
  logic [AW-1:0] ct_wraddr;
  logic [DW-1:0] ct_data;
  logic          ds;
  logic [AW-1:0] rdaddr1;
  logic [DW-1:0] mod_n;
  logic [DW-1:0] exp_d;
  logic          pt_rden;
  logic [AW-1:0] pt_rdaddr;
  logic [DW-1:0] pt_dataout;
  logic [DW-1:0] pt_org;
  logic          d_d;
  logic          busy;
  logic          err;

  modport master (
    output ct_wren, ct_wraddr, ct_data, ds, rdaddr1, mod_n, exp_d, pt_rden, pt_rdaddr,
    input  pt_dataout, pt_org, d_d, busy, err
  );

  modport slave (
    input  ct_wren, ct_wraddr, ct_data, ds, rdaddr1, mod_n, exp_d, pt_rden, pt_rdaddr,
    output pt_dataout, pt_org, d_d, busy, err
  );
endinterface

// File: rtl/rsa_modmul_seq.sv
// Sequential modular multiplier: one cycle to form a*b, then 2*DW restoring
// reduction steps. The result is presented combinationally alongside done_o
// so the caller can start the next operation on the very next cycle.
module rsa_modmul_seq #(
  parameter int DW = rsa_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] n_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] result_o
);
  localparam int CW = $clog2(2 * DW + 1);

  logic [2*DW-1:0] p_q, p_d;
  logic [DW-1:0]   r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [DW:0]     r_shift;
  logic [DW-1:0]   r_next;

  // One restoring step: bring in the next product bit, subtract n if it fits.
  always_comb begin
    r_shift = {r_q, p_q[2*DW-1]};
    r_next  = (r_shift >= {1'b0, n_i}) ? DW'(r_shift - {1'b0, n_i}) : r_shift[DW-1:0];
  end

  // Product load on start, then one reduction step per cycle.
  always_comb begin
    p_d    = p_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      p_d   = p_q << 1;
      r_d   = r_next;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end else if (start_i) begin
      p_d    = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
      r_d    = '0;
      cnt_d  = CW'(2 * DW);
      busy_d = 1'b1;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = busy_q && (cnt_q == CW'(1));
  assign result_o = r_next;

endmodule

// File: rtl/rsa_decrypt_core.sv
// RSA decryption core: ciphertext RAM, constant-time square-and-multiply
// exponentiation over a sequential modmul, plaintext RAM and status outputs.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for ds; latches address, n and d on accept
//   S_FETCH | read ciphertext word into c
//   S_INIT  | range check (n<2 or c>=n -> err); seed res=1, base=c
//   S_EXP   | DW bits LSB first, each: res*base (kept if bit set), base^2
//   S_WRITE | store res to plaintext RAM and pt_org
//   S_DONE  | one-cycle d_d pulse
module rsa_decrypt_core #(
  parameter int DW = rsa_pkg::DW,
  parameter int AW = rsa_pkg::AW
) (
  input logic clk,
  input logic rst,
  rsa_decrypt_core_if.slave bus
);
  import rsa_pkg::*;

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] n_q, n_d, e_q, e_d, c_q, c_d;
  logic [DW-1:0] res_q, res_d, base_q, base_d, pt_org_q, pt_org_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          phase_q, phase_d;
  logic          err_q, err_d;
  logic [DW-1:0] pt_dataout_q;
  logic          pt_we;

  logic [DW-1:0] ct_mem [2**AW];
  logic [DW-1:0] pt_mem [2**AW];

  logic          mm_start, mm_busy, mm_done;
  logic [DW-1:0] mm_a, mm_result;

  // phase 0 multiplies res*base, phase 1 squares base.
  assign mm_a = phase_q ? base_q : res_q;

  rsa_modmul_seq #(.DW(DW)) u_modmul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mm_start),
    .a_i      (mm_a),
    .b_i      (base_q),
    .n_i      (n_q),
    .busy_o   (mm_busy),
    .done_o   (mm_done),
    .result_o (mm_result)
  );

  // Next-state and datapath updates for the decrypt sequence.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    n_d      = n_q;
    e_d      = e_q;
    c_d      = c_q;
    res_d    = res_q;
    base_d   = base_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    err_d    = err_q;
    pt_org_d = pt_org_q;
    mm_start = 1'b0;
    pt_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ds) begin
          addr_d  = bus.rdaddr1;
          n_d     = bus.mod_n;
          e_d     = bus.exp_d;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        c_d     = ct_mem[addr_q];
        state_d = S_INIT;
      end
      S_INIT: begin
        if ((n_q < DW'(2)) || (c_q >= n_q)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          res_d   = DW'(1);
          base_d  = c_q;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = S_EXP;
        end
      end
      S_EXP: begin
        mm_start = !mm_busy;
        if (mm_done) begin
          if (!phase_q) begin
            if (e_q[bit_q]) res_d = mm_result;
            phase_d = 1'b1;
          end else begin
            base_d  = mm_result;
            phase_d = 1'b0;
            if (bit_q == BW'(DW - 1)) state_d = S_WRITE;
            else bit_d = bit_q + BW'(1);
          end
        end
      end
      S_WRITE: begin
        pt_we    = !rst;
        pt_org_d = res_q;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      n_q      <= '0;
      e_q      <= '0;
      c_q      <= '0;
      res_q    <= '0;
      base_q   <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      err_q    <= 1'b0;
      pt_org_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      n_q      <= n_d;
      e_q      <= e_d;
      c_q      <= c_d;
      res_q    <= res_d;
      base_q   <= base_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      err_q    <= err_d;
      pt_org_q <= pt_org_d;
    end
  end

  // Ciphertext RAM write port, open in every state.
  always_ff @(posedge clk) begin
    if (bus.ct_wren) ct_mem[bus.ct_wraddr] <= bus.ct_data;
  end

  // Plaintext RAM write port, driven only from WRITE.
  always_ff @(posedge clk) begin
    if (pt_we) pt_mem[addr_q] <= res_q;
  end

  // Registered plaintext RAM read, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) pt_dataout_q <= '0;
    else if (bus.pt_rden) pt_dataout_q <= pt_mem[bus.pt_rdaddr];
  end

  assign bus.pt_dataout = pt_dataout_q;
  assign bus.pt_org     = pt_org_q;
  assign bus.d_d        = (state_q == S_DONE);
  assign bus.busy       = (state_q == S_FETCH) || (state_q == S_INIT) ||
                          (state_q == S_EXP) || (state_q == S_WRITE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_rsa_decrypt_core.sv
// Self-checking bench for rsa_decrypt_core: vector table, corner sequences,
// and random operations against a plain-arithmetic modular power model.
module tb_rsa_decrypt_core;

  localparam int LAT_OK  = 114;
  localparam int LAT_ERR = 3;
  localparam int WIN     = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rsa_decrypt_core_if #(.DW(5), .AW(3)) bus ();

  rsa_decrypt_core #(.DW(5), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int exp_org = 0;
  int shadow [8];
  bit known [8];

  typedef struct {
    logic [2:0] addr;
    logic [4:0] ct;
    logic [4:0] n;
    logic [4:0] d;
    logic [4:0] pt;
    bit         err;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // m = c^d mod n by repeated multiplication, the plain definition.
  function automatic int model_pow(input int c, input int d, input int n);
    int r = 1;
    for (int k = 0; k < d; k++) r = (r * c) % n;
    return r;
  endfunction

  task automatic write_ct(input logic [2:0] a, input logic [4:0] v);
    bus.ct_wren = 1'b1; bus.ct_wraddr = a; bus.ct_data = v;
    tick();
    bus.ct_wren = 1'b0;
  endtask

  task automatic read_pt(input logic [2:0] a, output int v);
    bus.pt_rden = 1'b1; bus.pt_rdaddr = a;
    tick();
    bus.pt_rden = 1'b0;
    v = int'(bus.pt_dataout);
  endtask

  task automatic run_op(input logic [2:0] a, input logic [4:0] n, input logic [4:0] d,
                        input int ds_again_at, input int rst_at, input bit fetch_wr,
                        output int lat, output int ndone, output int busy1,
                        output int s_busy, output int s_dd, output int s_pt);
    lat = 0; ndone = 0; busy1 = 0; s_busy = -1; s_dd = -1; s_pt = -1;
    bus.ds = 1'b1; bus.rdaddr1 = a; bus.mod_n = n; bus.exp_d = d;
    tick();
    bus.ds = 1'b0; bus.rdaddr1 = ~a; bus.mod_n = 5'd0; bus.exp_d = 5'd0;
    for (int cyc = 1; cyc <= WIN; cyc++) begin
      if (cyc == 1) busy1 = int'(bus.busy);
      if (bus.d_d) begin
        ndone++;
        if (lat == 0) lat = cyc;
      end
      if (rst_at > 0 && cyc == rst_at + 1) begin
        s_busy = int'(bus.busy); s_dd = int'(bus.d_d); s_pt = int'(bus.pt_org);
      end
      if (fetch_wr && cyc == 1) begin
        bus.ct_wren = 1'b1; bus.ct_wraddr = a; bus.ct_data = 5'd9;
      end
      if (cyc == ds_again_at) begin
        bus.ds = 1'b1; bus.rdaddr1 = a + 3'd1; bus.mod_n = 5'd22; bus.exp_d = 5'd3;
      end
      if (rst_at > 0 && cyc == rst_at) rst = 1'b1;
      tick();
      bus.ct_wren = 1'b0; bus.ds = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic op_and_check(input string tag, input logic [2:0] a, input logic [4:0] ct,
                              input logic [4:0] n, input logic [4:0] d,
                              input int exp_pt, input bit exp_err);
    int lat, nd, b1, sb, sd, sp, rv;
    write_ct(a, ct);
    run_op(a, n, d, 0, 0, 1'b0, lat, nd, b1, sb, sd, sp);
    chk({tag, "_lat"}, lat, exp_err ? LAT_ERR : LAT_OK);
    chk({tag, "_ndone"}, nd, 1);
    chk({tag, "_busy"}, b1, 1);
    chk({tag, "_err"}, int'(bus.err), int'(exp_err));
    if (!exp_err) begin
      exp_org = exp_pt; shadow[a] = exp_pt; known[a] = 1'b1;
    end
    chk({tag, "_pt_org"}, int'(bus.pt_org), exp_org);
    if (known[a]) begin
      read_pt(a, rv);
      chk({tag, "_ptram"}, rv, shadow[a]);
    end
  endtask

  initial begin
    int lat, nd, b1, sb, sd, sp, rv;
    logic [2:0] ra;
    logic [4:0] rn, rc, rd;
    int rexp;
    bit rerr;

    vecs[0]  = '{3'd0, 5'd15, 5'd22, 5'd7, 5'd5, 1'b0};
    vecs[1]  = '{3'd0, 5'd0,  5'd22, 5'd7, 5'd0, 1'b0};
    vecs[2]  = '{3'd1, 5'd1,  5'd22, 5'd7, 5'd1, 1'b0};
    vecs[3]  = '{3'd2, 5'd8,  5'd22, 5'd7, 5'd2, 1'b0};
    vecs[4]  = '{3'd3, 5'd5,  5'd22, 5'd7, 5'd3, 1'b0};
    vecs[5]  = '{3'd4, 5'd20, 5'd22, 5'd7, 5'd4, 1'b0};
    vecs[6]  = '{3'd5, 5'd15, 5'd22, 5'd7, 5'd5, 1'b0};
    vecs[7]  = '{3'd6, 5'd18, 5'd22, 5'd7, 5'd6, 1'b0};
    vecs[8]  = '{3'd7, 5'd13, 5'd22, 5'd7, 5'd7, 1'b0};
    vecs[9]  = '{3'd6, 5'd1,  5'd22, 5'd7, 5'd1, 1'b0};
    vecs[10] = '{3'd7, 5'd0,  5'd22, 5'd7, 5'd0, 1'b0};
    vecs[11] = '{3'd2, 5'd15, 5'd22, 5'd0, 5'd1, 1'b0};
    vecs[12] = '{3'd4, 5'd0,  5'd1,  5'd7, 5'd0, 1'b1};
    vecs[13] = '{3'd1, 5'd25, 5'd22, 5'd7, 5'd0, 1'b1};
    vecs[14] = '{3'd3, 5'd5,  5'd22, 5'd7, 5'd3, 1'b0};

    for (int i = 0; i < 8; i++) begin shadow[i] = 0; known[i] = 1'b0; end
    bus.ct_wren = 1'b0; bus.ct_wraddr = '0; bus.ct_data = '0;
    bus.ds = 1'b0; bus.rdaddr1 = '0; bus.mod_n = '0; bus.exp_d = '0;
    bus.pt_rden = 1'b0; bus.pt_rdaddr = '0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pt_org", int'(bus.pt_org), 0);
    chk("rst_pt_dataout", int'(bus.pt_dataout), 0);
    chk("rst_d_d", int'(bus.d_d), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.err), 0);

    for (int i = 0; i < 15; i++)
      op_and_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ct, vecs[i].n,
                   vecs[i].d, int'(vecs[i].pt), vecs[i].err);

    // ds pulsed mid-operation must be dropped, not queued.
    run_op(3'd5, 5'd22, 5'd7, 40, 0, 1'b0, lat, nd, b1, sb, sd, sp);
    chk("dsbusy_lat", lat, LAT_OK);
    chk("dsbusy_ndone", nd, 1);
    chk("dsbusy_pt_org", int'(bus.pt_org), 5);
    exp_org = 5;

    // Reset at T+50 aborts the operation.
    run_op(3'd5, 5'd22, 5'd7, 0, 50, 1'b0, lat, nd, b1, sb, sd, sp);
    chk("rstmid_ndone", nd, 0);
    chk("rstmid_busy", sb, 0);
    chk("rstmid_d_d", sd, 0);
    chk("rstmid_pt_org", sp, 0);
    chk("rstmid_err", int'(bus.err), 0);
    exp_org = 0;
    read_pt(3'd5, rv);
    chk("rstmid_ptram", rv, 5);

    // Ciphertext RAM survives reset.
    run_op(3'd5, 5'd22, 5'd7, 0, 0, 1'b0, lat, nd, b1, sb, sd, sp);
    chk("postrst_lat", lat, LAT_OK);
    chk("postrst_pt_org", int'(bus.pt_org), 5);
    exp_org = 5;

    // Write to the fetched address during FETCH: old ciphertext is used.
    run_op(3'd5, 5'd22, 5'd7, 0, 0, 1'b1, lat, nd, b1, sb, sd, sp);
    chk("fetchwr_lat", lat, LAT_OK);
    chk("fetchwr_pt_org", int'(bus.pt_org), 5);
    // The new word (9) is now in place: 9^7 mod 22.
    run_op(3'd5, 5'd22, 5'd7, 0, 0, 1'b0, lat, nd, b1, sb, sd, sp);
    chk("fetchwr_new_pt_org", int'(bus.pt_org), model_pow(9, 7, 22));
    exp_org = model_pow(9, 7, 22);
    shadow[5] = exp_org;

    for (int i = 0; i < 40; i++) begin
      ra = 3'($urandom_range(0, 7));
      rn = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      if (($urandom % 4) != 0 && rn != 5'd0) rc = 5'($urandom % int'(rn));
      else rc = 5'($urandom_range(0, 31));
      rerr = (rn < 5'd2) || (rc >= rn);
      rexp = rerr ? 0 : model_pow(int'(rc), int'(rd), int'(rn));
      op_and_check($sformatf("rnd%0d", i), ra, rc, rn, rd, rexp, rerr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
